// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that lets several requesters share one
// UART transmitter. It captures one byte from the winner, strobes the UART,
// tracks busy_flag until the frame ends and reports done or a start timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic                   tx_en,
    output logic                   begin_flag,
    output logic [7:0]             tx_data,
    input  logic                   busy_flag,
    output logic [2:0]             owner
);

    localparam int unsigned CW = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           last_q, last_d;
    logic [2:0]           owner_q, owner_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_en_q, tx_en_d;
    logic                 begin_q, begin_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [7:0]           req_ext;
    logic                 win_found;
    logic [2:0]           win_idx;
    logic [7:0]           win_data;

    // Requester index reached by stepping 'step' places past 'base', modulo NUM_REQ.
    function automatic logic [2:0] rr_idx(input logic [2:0] base, input int unsigned step);
        int unsigned s;
        s = (32'(base) + step) % NUM_REQ;
        return s[2:0];
    endfunction

    // Round-robin search starting just after the last owner; first hit wins.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        win_found            = 1'b0;
        win_idx              = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && req_ext[rr_idx(last_q, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_idx(last_q, i);
            end
        end
    end

    // Byte lane of the winning requester.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == win_idx) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        tx_en_d   = tx_en_q;
        cnt_d     = cnt_q;
        begin_d   = 1'b0;
        ack_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && win_found) begin
                    tx_data_d = win_data;
                    owner_d   = win_idx;
                    ack_d     = NUM_REQ'(1) << win_idx;
                    tx_en_d   = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                // Strobe is registered, so it is visible for the first WAIT_BUSY cycle.
                begin_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_flag) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    tx_en_d = 1'b0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy_flag) begin
                    done_d  = NUM_REQ'(1) << owner_q;
                    last_d  = owner_q;
                    tx_en_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 3'(NUM_REQ - 1);
            owner_q   <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            begin_q   <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            begin_q   <= begin_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign err        = err_q;
    assign tx_en      = tx_en_q;
    assign begin_flag = begin_q;
    assign tx_data    = tx_data_q;
    assign owner      = owner_q;

endmodule
